// File: rtl/cnn_pkg.sv
// Shared fp16 types and compare helpers for the LeNet datapath.
// Macro POOL_RELU_EN: operands are ReLU'd, so max is an unsigned compare; otherwise signed fp16 compare.
package cnn_pkg;

  localparam int FP16_W = 16;
  localparam int FP16_SIGN = 15;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  typedef logic [FP16_W-1:0] fp16_t;

  function automatic fp16_t fp16_relu(input fp16_t x);
    fp16_t r;
    if (x[FP16_SIGN]) begin
      r = FP16_ZERO;
    end else begin
      r = x;
    end
    return r;
  endfunction

  // Strict a > b; ties (including +0 vs -0) return 0 so callers keep the earlier operand.
  function automatic logic fp16_gt(input fp16_t a, input fp16_t b);
    logic gt;
`ifndef POOL_RELU_EN
    logic [FP16_SIGN-1:0] a_mag;
    logic [FP16_SIGN-1:0] b_mag;
`endif
`ifdef POOL_RELU_EN
    gt = (a > b);
`else
    a_mag = a[FP16_SIGN-1:0];
    b_mag = b[FP16_SIGN-1:0];
    case ({a[FP16_SIGN], b[FP16_SIGN]})
      2'b00:   gt = (a_mag > b_mag);
      2'b11:   gt = (a_mag < b_mag);
      2'b01:   gt = (a_mag != 15'h0000) || (b_mag != 15'h0000);
      2'b10:   gt = 1'b0;
      default: gt = 1'b0;
    endcase
`endif
    return gt;
  endfunction

endpackage

// File: rtl/fp16_max2.sv
// Combinational two-operand fp16 max; on a tie the first operand (a_i) is kept.
// Compare flavour follows POOL_RELU_EN through cnn_pkg::fp16_gt.
module fp16_max2
  import cnn_pkg::*;
(
  input  fp16_t a_i,
  input  fp16_t b_i,
  output fp16_t max_o
);

  // Select the larger operand, preferring a_i on equality.
  always_comb begin
    if (fp16_gt(b_i, a_i)) begin
      max_o = b_i;
    end else begin
      max_o = a_i;
    end
  end

endmodule

// File: rtl/max_pool_relu_stream.sv
// Streaming ReLU + 2x2 stride-2 max pool over K channel-major fp16 maps of H x W pixels.
// Macro POOL_RELU_EN enables ReLU; without it the pool uses a signed fp16 max.
module max_pool_relu_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int H = 32,
  parameter int W = 32,
  parameter int K = 6,
  localparam int CH_W = (K > 1) ? $clog2(K) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic                  out_last
);

  localparam int COL_W = (W > 1) ? $clog2(W) : 1;
  localparam int ROW_W = (H > 1) ? $clog2(H) : 1;
  localparam int LB_D  = W / 2;
  localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

  if (((H % 2) != 0) || ((W % 2) != 0)) begin : g_bad_dims
    $error("max_pool_relu_stream: H and W must be even");
  end
  if (DATA_WIDTH != FP16_W) begin : g_bad_width
    $error("max_pool_relu_stream: DATA_WIDTH must be 16");
  end

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  fp16_t            p_q, p_d;
  fp16_t            lb_q [LB_D];
  logic [LB_AW-1:0] lb_idx_s;
  logic             lb_we_s;
  fp16_t            px_s, lb_rd_s, pair_s, win_s;
  logic             accept_s, col_last_s, row_last_s, ch_last_s;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  fp16_t            out_data_q, out_data_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;

`ifdef POOL_RELU_EN
  assign px_s = fp16_relu(in_data);
`else
  assign px_s = in_data;
`endif

  assign in_ready   = !out_valid_q || out_ready;
  assign accept_s   = in_valid && in_ready;
  assign col_last_s = (col_q == COL_W'(W - 1));
  assign row_last_s = (row_q == ROW_W'(H - 1));
  assign ch_last_s  = (ch_q == CH_W'(K - 1));
  assign lb_idx_s   = LB_AW'(col_q >> 1);
  assign lb_rd_s    = lb_q[lb_idx_s];

  // Pair stage covers the two pixels of the current row; window stage folds in the row above.
  fp16_max2 u_pair (.a_i(p_q),     .b_i(px_s),   .max_o(pair_s));
  fp16_max2 u_win  (.a_i(lb_rd_s), .b_i(pair_s), .max_o(win_s));

  // Next-state for counters, pair register and output register.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    ch_d        = ch_q;
    p_d         = p_q;
    lb_we_s     = 1'b0;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (accept_s) begin
      if (col_last_s) begin
        col_d = '0;
        if (row_last_s) begin
          row_d = '0;
          if (ch_last_s) begin
            ch_d = '0;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
      if (!col_q[0]) begin
        p_d = px_s;
      end else if (!row_q[0]) begin
        lb_we_s = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = win_s;
        out_ch_d    = ch_q;
        out_last_d  = ch_last_s && row_last_s && col_last_s;
      end
    end else begin
      lb_we_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      ch_q        <= '0;
      p_q         <= FP16_ZERO;
      out_valid_q <= 1'b0;
      out_data_q  <= FP16_ZERO;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      ch_q        <= ch_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffer: every even row writes before the odd row reads, so no reset is needed.
  always_ff @(posedge clk) begin
    if (lb_we_s) begin
      lb_q[lb_idx_s] <= pair_s;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_max_pool_relu_stream.sv
// Self-checking bench: a 4x4x1 instance for directed windows and a 32x32x6 instance for random frames.
// Expected results come from a window-fold reference model that honours POOL_RELU_EN.
module tb_max_pool_relu_stream;

  logic clk;
  int   cyc;
  int   checks;
  int   failures;
  bit   hung;

  logic        b_reset, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [15:0] b_in_data, b_out_data;
  logic [2:0]  b_out_ch;

  logic        s_reset, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last;
  logic [15:0] s_in_data, s_out_data;
  logic [0:0]  s_out_ch;

  logic [15:0] bq_data[$];
  int          bq_ch[$];
  bit          bq_last[$];
  logic [15:0] sq_data[$];
  bit          sq_last[$];
  int          sq_cyc[$];
  int          s_acc[$];
  int          stall_viol;
  bit          toggle_rdy;

  logic [15:0] frm[$];
  logic [15:0] e_data[$];
  int          e_ch[$];
  bit          e_last[$];

  max_pool_relu_stream #(.DATA_WIDTH(16), .H(32), .W(32), .K(6)) u_big (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ch(b_out_ch), .out_last(b_out_last));

  max_pool_relu_stream #(.DATA_WIDTH(16), .H(4), .W(4), .K(1)) u_small (
    .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_ch(s_out_ch), .out_last(s_out_last));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (b_out_valid && b_out_ready) begin
      bq_data.push_back(b_out_data);
      bq_ch.push_back(int'(b_out_ch));
      bq_last.push_back(b_out_last);
    end
    if (b_out_valid && !b_out_ready && b_in_ready) stall_viol++;
    if (s_out_valid && s_out_ready) begin
      sq_data.push_back(s_out_data);
      sq_last.push_back(s_out_last);
      sq_cyc.push_back(cyc);
    end
  end

  // Value entering the pool: ReLU'd or raw depending on the build.
  function automatic logic [15:0] val(input logic [15:0] x);
`ifdef POOL_RELU_EN
    return x[15] ? 16'h0000 : x;
`else
    return x;
`endif
  endfunction

  // Signed ordering key: +x -> |x|, -x -> -|x|, so +0 and -0 tie.
  function automatic int key(input logic [15:0] x);
    int m;
    m = int'({17'd0, x[14:0]});
    return x[15] ? -m : m;
  endfunction

  // Fold each 2x2 window in arrival order, keeping the first maximum on ties.
  task automatic model_frame(input int base, input int h, input int w, input int k);
    logic [15:0] best, v;
    for (int ch = 0; ch < k; ch++)
      for (int r = 0; r < h; r += 2)
        for (int c = 0; c < w; c += 2) begin
          best = val(frm[base + ch*h*w + r*w + c]);
          for (int j = 1; j < 4; j++) begin
            v = val(frm[base + ch*h*w + (r + j/2)*w + c + (j%2)]);
            if (key(v) > key(best)) best = v;
          end
          e_data.push_back(best);
          e_ch.push_back(ch);
          e_last.push_back((ch == k-1) && (r == h-2) && (c == w-2));
        end
  endtask

  task automatic clear_all();
    bq_data.delete(); bq_ch.delete(); bq_last.delete();
    sq_data.delete(); sq_last.delete(); sq_cyc.delete(); s_acc.delete();
    frm.delete(); e_data.delete(); e_ch.delete(); e_last.delete();
    stall_viol = 0;
  endtask

  task automatic do_reset();
    b_reset = 1'b1; s_reset = 1'b1;
    b_in_valid = 1'b0; s_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    b_reset = 1'b0; s_reset = 1'b0;
  endtask

  task automatic b_send(input logic [15:0] px);
    bit done;
    done = 1'b0;
    if (!hung) begin
      b_in_valid = 1'b1;
      b_in_data  = px;
      for (int t = 0; t < 64 && !done; t++) begin
        if (toggle_rdy) b_out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        else b_out_ready = 1'b1;
        @(negedge clk);
        if (b_in_ready) done = 1'b1;
        @(posedge clk);
        #1;
      end
      b_in_valid = 1'b0;
      if (!done) begin
        hung = 1'b1; checks++; failures++;
        $display("FAIL big_in_ready_timeout got=stalled exp=accept within 64 cycles");
      end
    end
  endtask

  task automatic s_send(input logic [15:0] px);
    bit done;
    done = 1'b0;
    s_in_valid = 1'b1;
    s_in_data  = px;
    for (int t = 0; t < 16 && !done; t++) begin
      @(negedge clk);
      if (s_in_ready) begin
        done = 1'b1;
        s_acc.push_back(cyc);
      end
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL small_in_ready_timeout got=stalled exp=accept within 16 cycles");
    end
  endtask

  task automatic drain();
    b_out_ready = 1'b1; s_out_ready = 1'b1; toggle_rdy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare_big(input string name);
    int n;
    checks++;
    if (bq_data.size() != e_data.size()) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=%0d", name, bq_data.size(), e_data.size());
    end
    n = (bq_data.size() < e_data.size()) ? bq_data.size() : e_data.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (bq_data[i] !== e_data[i] || bq_ch[i] != e_ch[i] || bq_last[i] !== e_last[i]) begin
        failures++;
        $display("FAIL %s_out[%0d] got=%h/ch%0d/last%0b exp=%h/ch%0d/last%0b", name, i,
                 bq_data[i], bq_ch[i], bq_last[i], e_data[i], e_ch[i], e_last[i]);
      end
    end
  endtask

  task automatic test_reset();
    b_out_ready = 1'b0; s_out_ready = 1'b0;
    do_reset();
    @(negedge clk);
    checks++;
    if ({b_out_valid, b_out_data, b_out_ch, b_out_last} !== 21'd0) begin
      failures++;
      $display("FAIL reset_big got=%b/%h/%0d/%b exp=0/0000/0/0", b_out_valid, b_out_data, b_out_ch, b_out_last);
    end
    checks++;
    if ({s_out_valid, s_out_data, s_out_ch, s_out_last} !== 19'd0) begin
      failures++;
      $display("FAIL reset_small got=%b/%h/%0d/%b exp=0/0000/0/0", s_out_valid, s_out_data, s_out_ch, s_out_last);
    end
    checks++;
    if (b_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", b_in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_small_ramp();
    logic [15:0] exp_d [4];
    int          comp_idx [4];
    exp_d    = '{16'h4100, 16'h4300, 16'h4900, 16'h4B00};
    comp_idx = '{5, 7, 13, 15};
    do_reset();
    clear_all();
    s_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) s_send(16'h3C00 + 16'(i * 256));
    drain();
    checks++;
    if (sq_data.size() != 4) begin
      failures++;
      $display("FAIL ramp_count got=%0d exp=4", sq_data.size());
    end
    for (int i = 0; i < 4 && i < sq_data.size(); i++) begin
      checks++;
      if (sq_data[i] !== exp_d[i] || sq_last[i] !== (i == 3)) begin
        failures++;
        $display("FAIL ramp_out[%0d] got=%h/last%0b exp=%h/last%0b", i, sq_data[i], sq_last[i], exp_d[i], (i == 3));
      end
      checks++;
      if (sq_cyc[i] != s_acc[comp_idx[i]] + 1) begin
        failures++;
        $display("FAIL ramp_latency[%0d] got=%0d exp=%0d", i, sq_cyc[i] - s_acc[comp_idx[i]], 1);
      end
    end
  endtask

  task automatic test_window_cases();
    logic [15:0] win [4][4];
    logic [15:0] exp_d [4];
    win[0] = '{16'hBC00, 16'hC000, 16'hB800, 16'h8000};
    win[1] = '{16'h3800, 16'h0000, 16'h7C00, 16'h3C00};
    win[2] = '{16'h8000, 16'h0000, 16'h8000, 16'h0000};
    win[3] = '{16'h7E00, 16'h7C00, 16'hFE00, 16'h3C00};
`ifdef POOL_RELU_EN
    exp_d = '{16'h0000, 16'h7C00, 16'h0000, 16'h7E00};
`else
    // -0 has the smallest magnitude, so it is the largest negative; a +/-0 tie keeps the first.
    exp_d = '{16'h8000, 16'h7C00, 16'h8000, 16'h7E00};
`endif
    do_reset();
    clear_all();
    s_out_ready = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s_send(win[(r/2)*2 + c/2][(r%2)*2 + c%2]);
    drain();
    checks++;
    if (sq_data.size() != 4) begin
      failures++;
      $display("FAIL window_count got=%0d exp=4", sq_data.size());
    end
    for (int i = 0; i < 4 && i < sq_data.size(); i++) begin
      checks++;
      if (sq_data[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL window[%0d] got=%h exp=%h", i, sq_data[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_full_frame_backpressure();
    int cnt [6];
    do_reset();
    clear_all();
    for (int i = 0; i < 6144; i++) frm.push_back(16'($urandom));
    model_frame(0, 32, 32, 6);
    toggle_rdy = 1'b1;
    for (int i = 0; i < 6144; i++) b_send(frm[i]);
    drain();
    compare_big("frame");
    cnt = '{0, 0, 0, 0, 0, 0};
    foreach (bq_ch[i]) if (bq_ch[i] >= 0 && bq_ch[i] < 6) cnt[bq_ch[i]]++;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (cnt[c] != 256) begin
        failures++;
        $display("FAIL frame_ch%0d_count got=%0d exp=256", c, cnt[c]);
      end
    end
    checks++;
    if (stall_viol != 0) begin
      failures++;
      $display("FAIL frame_in_ready_stall got=%0d exp=0", stall_viol);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    clear_all();
    for (int i = 0; i < 100; i++) b_send(16'($urandom));
    b_out_ready = 1'b0;
    b_reset = 1'b1;
    @(posedge clk);
    #1;
    b_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (b_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_out_valid got=%b exp=0", b_out_valid);
    end
    @(posedge clk);
    #1;
    clear_all();
    for (int i = 0; i < 6144; i++) frm.push_back(16'($urandom));
    model_frame(0, 32, 32, 6);
    for (int i = 0; i < 6144; i++) b_send(frm[i]);
    drain();
    checks++;
    if (bq_data.size() == 0 || bq_data[0] !== e_data[0] || bq_ch[0] != 0) begin
      failures++;
      $display("FAIL midreset_first got=%h exp=%h", (bq_data.size() > 0) ? bq_data[0] : 16'hxxxx, e_data[0]);
    end
    compare_big("midreset");
  endtask

  task automatic test_back_to_back();
    int lasts;
    do_reset();
    clear_all();
    for (int i = 0; i < 12288; i++) frm.push_back(16'($urandom));
    model_frame(0, 32, 32, 6);
    model_frame(6144, 32, 32, 6);
    for (int i = 0; i < 12288; i++) b_send(frm[i]);
    drain();
    lasts = 0;
    foreach (bq_last[i]) if (bq_last[i]) lasts++;
    checks++;
    if (lasts != 2) begin
      failures++;
      $display("FAIL b2b_last_pulses got=%0d exp=2", lasts);
    end
    checks++;
    if (bq_ch.size() <= 1536 || bq_ch[1536] != 0) begin
      failures++;
      $display("FAIL b2b_second_first_ch got=%0d exp=0", (bq_ch.size() > 1536) ? bq_ch[1536] : -1);
    end
    compare_big("b2b");
  endtask

  initial begin
    checks = 0; failures = 0; hung = 1'b0; toggle_rdy = 1'b0; stall_viol = 0;
    b_reset = 1'b1; s_reset = 1'b1;
    b_in_valid = 1'b0; s_in_valid = 1'b0;
    b_in_data = 16'h0000; s_in_data = 16'h0000;
    b_out_ready = 1'b0; s_out_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_small_ramp();
    test_window_cases();
    test_full_frame_backpressure();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
